// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, debounce counter, stable level, press/release pulses, sticky press flags.
// Optional macro BTN_IRQ_EN adds irq_mask_i and a registered active-low irq_n.
module button_debouncer #(
    parameter int   WIDTH           = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_i,
    output logic [WIDTH-1:0] btn_o,
    output logic [WIDTH-1:0] press_o,
    output logic [WIDTH-1:0] release_o,
    output logic [WIDTH-1:0] evt_o,
    input  logic [WIDTH-1:0] evt_clr_i
`ifdef BTN_IRQ_EN
    ,
    input  logic [WIDTH-1:0] irq_mask_i,
    output logic             irq_n
`endif
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0]            sync1_q;
    logic [WIDTH-1:0]            sync2_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            stable_q;
    logic [WIDTH-1:0]            stable_d;
    logic [WIDTH-1:0]            press_q;
    logic [WIDTH-1:0]            press_d;
    logic [WIDTH-1:0]            release_q;
    logic [WIDTH-1:0]            release_d;
    logic [WIDTH-1:0]            evt_q;
    logic [WIDTH-1:0]            evt_d;

    // Any cycle where the synchronised level matches the stable level restarts the count,
    // so only an uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted.
    always_comb begin
        cnt_d     = '0;
        stable_d  = stable_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    if (sync2_q[i] == IDLE_LEVEL) begin
                        release_d[i] = 1'b1;
                    end else begin
                        press_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        // A press landing in the same cycle as a clear must not be lost.
        evt_d = (evt_q & ~evt_clr_i) | press_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= {WIDTH{IDLE_LEVEL}};
            sync2_q   <= {WIDTH{IDLE_LEVEL}};
            cnt_q     <= '0;
            stable_q  <= {WIDTH{IDLE_LEVEL}};
            press_q   <= '0;
            release_q <= '0;
            evt_q     <= '0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            evt_q     <= evt_d;
        end
    end

    assign btn_o     = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign evt_o     = evt_q;

`ifdef BTN_IRQ_EN
    logic irq_n_q;
    logic irq_n_d;

    // Built from the next-state flags so the request tracks evt_o cycle for cycle.
    always_comb begin
        irq_n_d = ~|(evt_d & irq_mask_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_n_q <= 1'b1;
        end else begin
            irq_n_q <= irq_n_d;
        end
    end

    assign irq_n = irq_n_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with WIDTH=2, DEBOUNCE_CYCLES=4, IDLE_LEVEL=1.
module tb_button_debouncer;

    logic       clk;
    logic       reset;
    logic [1:0] btn_i;
    logic [1:0] btn_o;
    logic [1:0] press_o;
    logic [1:0] release_o;
    logic [1:0] evt_o;
    logic [1:0] evt_clr_i;
`ifdef BTN_IRQ_EN
    logic [1:0] irq_mask_i;
    logic       irq_n;
`endif

    int total = 0;
    int bad   = 0;

    button_debouncer #(
        .WIDTH(2),
        .DEBOUNCE_CYCLES(4),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_i(btn_i),
        .btn_o(btn_o),
        .press_o(press_o),
        .release_o(release_o),
        .evt_o(evt_o),
        .evt_clr_i(evt_clr_i)
`ifdef BTN_IRQ_EN
        ,
        .irq_mask_i(irq_mask_i),
        .irq_n(irq_n)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Observed vector layout: {btn_o, press_o, release_o, evt_o}
    task automatic test_reset;
        logic [7:0] exp;
        reset = 1'b1;
        btn_i = 2'b11;
        evt_clr_i = 2'b00;
`ifdef BTN_IRQ_EN
        irq_mask_i = 2'b00;
`endif
        tick();
        tick();
        exp = {2'b11, 2'b00, 2'b00, 2'b00};
        total++;
        if ({btn_o, press_o, release_o, evt_o} !== exp) begin
            bad++;
            $display("FAIL reset_state got=%b exp=%b", {btn_o, press_o, release_o, evt_o}, exp);
        end
`ifdef BTN_IRQ_EN
        total++;
        if (irq_n !== 1'b1) begin
            bad++;
            $display("FAIL reset_irq_n got=%b exp=1", irq_n);
        end
`endif
        reset = 1'b0;
        tick();
        total++;
        if ({btn_o, press_o, release_o, evt_o} !== exp) begin
            bad++;
            $display("FAIL reset_first_cycle got=%b exp=%b", {btn_o, press_o, release_o, evt_o}, exp);
        end
        // Reset mid-count: the full debounce interval must restart afterwards.
        btn_i = 2'b10;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            exp = (t == 6) ? {2'b10, 2'b01, 2'b00, 2'b01} : {2'b11, 2'b00, 2'b00, 2'b00};
            total++;
            if ({btn_o, press_o, release_o, evt_o} !== exp) begin
                bad++;
                $display("FAIL reset_midcount t=%0d got=%b exp=%b", t, {btn_o, press_o, release_o, evt_o}, exp);
            end
        end
        btn_i = 2'b11;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        exp = {2'b11, 2'b00, 2'b00, 2'b00};
        total++;
        if ({btn_o, press_o, release_o, evt_o} !== exp) begin
            bad++;
            $display("FAIL reset_clean got=%b exp=%b", {btn_o, press_o, release_o, evt_o}, exp);
        end
    endtask

    task automatic test_press_ch0;
        logic [7:0] exp;
        btn_i = 2'b10;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (t < 6)       exp = {2'b11, 2'b00, 2'b00, 2'b00};
            else if (t == 6) exp = {2'b10, 2'b01, 2'b00, 2'b01};
            else             exp = {2'b10, 2'b00, 2'b00, 2'b01};
            total++;
            if ({btn_o, press_o, release_o, evt_o} !== exp) begin
                bad++;
                $display("FAIL press_ch0 t=%0d got=%b exp=%b", t, {btn_o, press_o, release_o, evt_o}, exp);
            end
        end
    endtask

    task automatic test_glitch_ch1;
        logic [7:0] exp;
        exp = {2'b10, 2'b00, 2'b00, 2'b01};
        btn_i = 2'b00;
        repeat (3) tick();
        btn_i = 2'b10;
        for (int t = 1; t <= 8; t++) begin
            tick();
            total++;
            if ({btn_o, press_o, release_o, evt_o} !== exp) begin
                bad++;
                $display("FAIL glitch_ch1 t=%0d got=%b exp=%b", t, {btn_o, press_o, release_o, evt_o}, exp);
            end
        end
    endtask

    task automatic test_bounce_ch1;
        logic [7:0] exp;
        logic [4:0] pattern;
        pattern = 5'b01010;
        for (int b = 4; b >= 1; b--) begin
            btn_i = {pattern[b], 1'b0};
            tick();
            exp = {2'b10, 2'b00, 2'b00, 2'b01};
            total++;
            if ({btn_o, press_o, release_o, evt_o} !== exp) begin
                bad++;
                $display("FAIL bounce_ch1 step=%0d got=%b exp=%b", b, {btn_o, press_o, release_o, evt_o}, exp);
            end
        end
        btn_i = 2'b00;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t < 6)       exp = {2'b10, 2'b00, 2'b00, 2'b01};
            else if (t == 6) exp = {2'b00, 2'b10, 2'b00, 2'b11};
            else             exp = {2'b00, 2'b00, 2'b00, 2'b11};
            total++;
            if ({btn_o, press_o, release_o, evt_o} !== exp) begin
                bad++;
                $display("FAIL bounce_settle t=%0d got=%b exp=%b", t, {btn_o, press_o, release_o, evt_o}, exp);
            end
        end
    endtask

    task automatic test_evt_clear;
        logic [7:0] exp;
        evt_clr_i = 2'b01;
        tick();
        evt_clr_i = 2'b00;
        total++;
        if (evt_o !== 2'b10) begin
            bad++;
            $display("FAIL evt_clear got=%b exp=10", evt_o);
        end
        evt_clr_i = 2'b01;
        tick();
        evt_clr_i = 2'b00;
        total++;
        if (evt_o !== 2'b10) begin
            bad++;
            $display("FAIL evt_clear_idle got=%b exp=10", evt_o);
        end
        // Releases pulse release_o but never set a flag.
        btn_i = 2'b11;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t < 6)       exp = {2'b00, 2'b00, 2'b00, 2'b10};
            else if (t == 6) exp = {2'b11, 2'b00, 2'b11, 2'b10};
            else             exp = {2'b11, 2'b00, 2'b00, 2'b10};
            total++;
            if ({btn_o, press_o, release_o, evt_o} !== exp) begin
                bad++;
                $display("FAIL release_both t=%0d got=%b exp=%b", t, {btn_o, press_o, release_o, evt_o}, exp);
            end
        end
        // Clear asserted on the very edge that registers a new press: set wins.
        btn_i = 2'b10;
        repeat (5) tick();
        evt_clr_i = 2'b01;
        tick();
        evt_clr_i = 2'b00;
        exp = {2'b10, 2'b01, 2'b00, 2'b11};
        total++;
        if ({btn_o, press_o, release_o, evt_o} !== exp) begin
            bad++;
            $display("FAIL set_and_clear got=%b exp=%b", {btn_o, press_o, release_o, evt_o}, exp);
        end
        tick();
        total++;
        if (evt_o !== 2'b11) begin
            bad++;
            $display("FAIL set_wins_hold got=%b exp=11", evt_o);
        end
        evt_clr_i = 2'b11;
        tick();
        evt_clr_i = 2'b00;
        total++;
        if (evt_o !== 2'b00) begin
            bad++;
            $display("FAIL clear_both got=%b exp=00", evt_o);
        end
    endtask

`ifdef BTN_IRQ_EN
    task automatic test_irq;
        logic [1:0] exp_evt;
        logic       exp_irq;
        irq_mask_i = 2'b10;
        btn_i = 2'b11;
        repeat (7) tick();
        btn_i = 2'b10;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_evt = (t >= 6) ? 2'b01 : 2'b00;
            total++;
            if ({irq_n, evt_o} !== {1'b1, exp_evt}) begin
                bad++;
                $display("FAIL irq_masked t=%0d got=%b exp=%b", t, {irq_n, evt_o}, {1'b1, exp_evt});
            end
        end
        btn_i = 2'b00;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_evt = (t >= 6) ? 2'b11 : 2'b01;
            exp_irq = (t >= 6) ? 1'b0 : 1'b1;
            total++;
            if ({irq_n, evt_o} !== {exp_irq, exp_evt}) begin
                bad++;
                $display("FAIL irq_enabled t=%0d got=%b exp=%b", t, {irq_n, evt_o}, {exp_irq, exp_evt});
            end
        end
        evt_clr_i = 2'b10;
        tick();
        evt_clr_i = 2'b00;
        total++;
        if ({irq_n, evt_o} !== 3'b101) begin
            bad++;
            $display("FAIL irq_clear got=%b exp=101", {irq_n, evt_o});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_press_ch0();
        test_glitch_ch1();
        test_bounce_ch1();
        test_evt_clear();
`ifdef BTN_IRQ_EN
        test_irq();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
